// File: rtl/sync_fifo_stream_rd.sv
// sync_fifo_stream_rd: drains the sync_fifo read port into a valid/ready stream through a 2-entry skid buffer.
// Define SYNC_FIFO_STREAM_RD_CNT_EN to add the xfer_cnt handshake counter output.
module sync_fifo_stream_rd #(
    parameter int DWIDTH = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              fifo_empty,
    input  logic [DWIDTH-1:0] fifo_dout,
    output logic              fifo_rden,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [DWIDTH-1:0] m_data,
    output logic              busy
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
    ,
    output logic [31:0]       xfer_cnt
`endif
);
    typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;
    state_t state, state_nxt;
    logic inflight, pop;
    logic [1:0] occ;
    logic [DWIDTH-1:0] head, skid, head_nxt, skid_nxt;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= EMPTY;
            inflight <= 1'b0;
            head     <= '0;
            skid     <= '0;
        end else begin
            state    <= state_nxt;
            inflight <= fifo_rden;
            head     <= head_nxt;
            skid     <= skid_nxt;
        end
    end
    always_comb begin
        state_nxt = state;
        head_nxt  = head;
        skid_nxt  = skid;
        m_valid   = state != EMPTY;
        pop       = m_valid && m_ready;
        occ       = state == TWO ? 2'd2 : state == ONE ? 2'd1 : 2'd0;
        case (state)
            EMPTY: if (inflight) begin
                state_nxt = ONE;
                head_nxt  = fifo_dout;
            end
            ONE: if (pop && inflight) begin
                head_nxt  = fifo_dout;
            end else if (pop) begin
                state_nxt = EMPTY;
            end else if (inflight) begin
                state_nxt = TWO;
                skid_nxt  = fifo_dout;
            end
            TWO: if (pop) begin
                state_nxt = ONE;
                head_nxt  = skid;
            end
            default: state_nxt = EMPTY;
        endcase
        // Only request a word if a slot is guaranteed once it lands, counting this cycle's pop.
        fifo_rden = !rst && !fifo_empty && (({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, pop}));
    end
    assign m_data = head;
    assign busy   = (state != EMPTY) || inflight;
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            xfer_cnt <= '0;
        else if (pop)
            xfer_cnt <= xfer_cnt + 32'd1;
    end
`endif
endmodule

// File: tb/tb_sync_fifo_stream_rd.sv
// tb_sync_fifo_stream_rd: random and directed checks of the stream read adapter against a queue-based FIFO and scoreboard.
module tb_sync_fifo_stream_rd;
    localparam int DW = 16;
    logic clk = 1'b0, rst = 1'b1, m_ready = 1'b0, wr_en = 1'b0;
    logic fifo_empty, fifo_rden, m_valid, busy;
    logic [DW-1:0] fifo_dout, m_data, wr_data = '0, prev_data = '0, d;
    logic prev_stall = 1'b0;
    logic [DW-1:0] q[$], exp_q[$], words[4];
    int fill = 0, rd_cnt = 0, del_cnt = 0, n_cmp = 0, n_bad = 0;
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
    logic [31:0] xfer_cnt;
`endif
    sync_fifo_stream_rd #(.DWIDTH(DW)) dut (
        .clk(clk), .rst(rst), .fifo_empty(fifo_empty), .fifo_dout(fifo_dout), .fifo_rden(fifo_rden),
        .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .busy(busy)
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
        , .xfer_cnt(xfer_cnt)
`endif
    );
    always #5 clk = ~clk;
    assign fifo_empty = (fill == 0);
    // Behavioural sync_fifo: registered read data, pops only when non-empty.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            q.delete();
            fill <= 0;
            rd_cnt <= 0;
            fifo_dout <= '0;
        end else begin
            if (fifo_rden && fill > 0) begin
                fifo_dout <= q.pop_front();
                rd_cnt <= rd_cnt + 1;
            end
            if (wr_en) q.push_back(wr_data);
            fill <= fill + int'(wr_en) - int'(fifo_rden && fill > 0);
        end
    end
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask
    task automatic step();
        #1;
        chk("rden_empty", 32'(fifo_rden & fifo_empty), 0);
        chk("busy", 32'(busy), 32'(rd_cnt != del_cnt));
        chk("outstanding_le2", 32'(rd_cnt - del_cnt <= 2), 1);
        if (prev_stall) chk("hold", {m_valid, m_data}, {1'b1, prev_data});
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
        chk("xfer_cnt", xfer_cnt, del_cnt);
`endif
        if (m_valid && m_ready) begin
            if (exp_q.size() == 0) chk("extra_word", exp_q.size(), 1);
            else chk("data", m_data, exp_q.pop_front());
            del_cnt++;
        end
        if (wr_en) exp_q.push_back(wr_data);
        prev_stall = m_valid && !m_ready;
        prev_data = m_data;
        @(posedge clk);
        #2;
    endtask
    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", m_valid, 0);
        chk("rst_rden", fifo_rden, 0);
        chk("rst_busy", busy, 0);
        chk("rst_data", m_data, 0);
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
        chk("rst_xfer_cnt", xfer_cnt, 0);
`endif
        @(posedge clk);
        #2;
        rst = 1'b0;
        exp_q.delete();
        del_cnt = 0;
        prev_stall = 1'b0;
    endtask
    initial begin
        int n, vc, rden_n, valid_n, written;
        repeat (2) @(posedge clk);
        #2;
        do_reset();
        m_ready = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'hA5A5;
        step();
        wr_en = 1'b0;
        n = -1; vc = -1; rden_n = 0; valid_n = 0; d = '0;
        for (int i = 0; i < 8; i++) begin
            #1;
            if (n < 0 && !fifo_empty) n = i;
            if (m_valid && vc < 0) begin vc = i; d = m_data; end
            rden_n += int'(fifo_rden);
            valid_n += int'(m_valid);
            step();
        end
        chk("single_latency", vc - n, 2);
        chk("single_data", d, 16'hA5A5);
        chk("single_rden_pulses", rden_n, 1);
        chk("single_valid_cycles", valid_n, 1);
        chk("single_busy_idle", busy, 0);
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1;
            wr_data = ~16'(i + 1);
            step();
        end
        wr_en = 1'b0;
        repeat (3) step();
        m_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("burst_valid", m_valid, 1);
            step();
        end
        chk("burst_end_valid", m_valid, 0);
        chk("burst_delivered", del_cnt, 8);
`ifdef SYNC_FIFO_STREAM_RD_CNT_EN
        chk("burst_xfer_cnt", xfer_cnt, 8);
`endif
        do_reset();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            words[i] = DW'($urandom);
            wr_en = 1'b1;
            wr_data = words[i];
            step();
        end
        wr_en = 1'b0;
        repeat (10) step();
        chk("stall_reads", rd_cnt, 2);
        chk("stall_valid", m_valid, 1);
        chk("stall_head", m_data, words[0]);
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("release_valid", m_valid, 1);
            step();
        end
        chk("release_delivered", del_cnt, 4);
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            wr_en = 1'b1;
            wr_data = DW'($urandom);
            step();
        end
        wr_en = 1'b0;
        repeat (4) step();
        chk("pre_rst_busy", busy, 1);
        do_reset();
        m_ready = 1'b1;
        wr_en = 1'b1;
        wr_data = 16'h1234;
        step();
        wr_en = 1'b0;
        vc = 0;
        for (int i = 0; i < 10 && vc == 0; i++) begin
            #1;
            if (m_valid) begin
                vc = 1;
                chk("post_rst_first", m_data, 16'h1234);
            end
            step();
        end
        chk("post_rst_seen", vc, 1);
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            written = 0;
            for (int i = 0; i < 800 && del_cnt < 50; i++) begin
                m_ready = phase == 0 ? ~i[0] : ($urandom_range(0, 2) != 0);
                wr_en = written < 50 && fill < 6 && $urandom_range(0, 3) != 0;
                wr_data = DW'($urandom);
                written += int'(wr_en);
                step();
            end
            wr_en = 1'b0;
            repeat (4) step();
            chk("random_delivered", del_cnt, 50);
            chk("random_left", exp_q.size(), 0);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
